// File: rtl/matrix_pkg.sv
// Shared constants, pixel type and fetch FSM states for the LED matrix row loader.
package matrix_pkg;
  localparam int COLS     = 32;
  localparam int ROWS     = 32;
  localparam int ROW_BITS = $clog2(ROWS / 2);
  localparam int COL_BITS = 5;
  localparam int ADDR_W   = 1 + ROW_BITS + COL_BITS;

  typedef struct packed {
    logic b;
    logic g;
    logic r;
  } rgb_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    LAST  = 2'd2,
    DONE  = 2'd3
  } state_t;

  function automatic logic [ADDR_W-1:0] ram_addr(input logic frame,
                                                 input logic [ROW_BITS-1:0] row,
                                                 input logic [COL_BITS-1:0] col);
    return {frame, row, col};
  endfunction
endpackage

// File: rtl/matrix_frame_ram.sv
// 1024 x 3 pixel store, one write port and one read port with one cycle of read latency.
module matrix_frame_ram
  import matrix_pkg::*;
(
  input  logic              i_clk,
  input  logic              i_wr_en,
  input  logic [ADDR_W-1:0] i_wr_addr,
  input  rgb_t              i_wr_data,
  input  logic [ADDR_W-1:0] i_rd_addr,
  output rgb_t              o_rd_data
);
  rgb_t r_mem [0:(2**ADDR_W)-1];
  rgb_t r_rd_data;

  always_ff @(posedge i_clk) begin
    if (i_wr_en) r_mem[i_wr_addr] <= i_wr_data;
    r_rd_data <= r_mem[i_rd_addr];
  end

  assign o_rd_data = r_rd_data;
endmodule

// File: rtl/matrix_row_loader.sv
// Double-buffered frame store and row-pair fetcher feeding the LED matrix driver.
// Handshake: ROW_REQ is a one-cycle pulse accepted only while BUSY is low; a pulse seen while BUSY is high is dropped (REQ_DROP), and ROW_DONE marks the cycle the colour words change.
module matrix_row_loader
  import matrix_pkg::*;
(
  input  logic                CLK_I,
  input  logic                RST_I,
  input  logic                WR_EN,
  input  logic [4:0]          WR_X,
  input  logic [4:0]          WR_Y,
  input  logic [2:0]          WR_RGB,
  input  logic                SWAP_REQ,
  input  logic                ROW_REQ,
  input  logic [ROW_BITS-1:0] ROW_ADDR,
  output logic                BUSY,
  output logic                ROW_DONE,
  output logic                REQ_DROP,
  output logic                SWAP_DONE,
  output logic                FRONT,
  output logic [COLS-1:0]     RED0,
  output logic [COLS-1:0]     GREEN0,
  output logic [COLS-1:0]     BLUE0,
  output logic [COLS-1:0]     RED1,
  output logic [COLS-1:0]     GREEN1,
  output logic [COLS-1:0]     BLUE1,
  output state_t              DBG_STATE
);
  state_t              r_state;
  logic                r_busy, r_front, r_pend;
  logic                r_row_done, r_req_drop, r_swap_done;
  logic [ROW_BITS-1:0] r_row;
  logic [COL_BITS-1:0] r_col, r_cap_col;
  logic                r_cap_vld;
  logic [COLS-1:0]     r_sh_r0, r_sh_g0, r_sh_b0, r_sh_r1, r_sh_g1, r_sh_b1;
  logic [COLS-1:0]     r_o_r0, r_o_g0, r_o_b0, r_o_r1, r_o_g1, r_o_b1;
  logic [COLS-1:0]     w_nx_r0, w_nx_g0, w_nx_b0, w_nx_r1, w_nx_g1, w_nx_b1;
  logic [ADDR_W-1:0]   w_wr_addr, w_rd_addr;
  rgb_t                w_top, w_bot;

  // Host writes always land in the back frame, so they never race the fetcher.
  assign w_wr_addr = ram_addr(~r_front, WR_Y[3:0], WR_X);
  assign w_rd_addr = ram_addr(r_front, r_row, r_col);

  matrix_frame_ram u_top (
    .i_clk(CLK_I), .i_wr_en(WR_EN & ~WR_Y[4]), .i_wr_addr(w_wr_addr),
    .i_wr_data(rgb_t'(WR_RGB)), .i_rd_addr(w_rd_addr), .o_rd_data(w_top)
  );

  matrix_frame_ram u_bot (
    .i_clk(CLK_I), .i_wr_en(WR_EN & WR_Y[4]), .i_wr_addr(w_wr_addr),
    .i_wr_data(rgb_t'(WR_RGB)), .i_rd_addr(w_rd_addr), .o_rd_data(w_bot)
  );

  always_comb begin
    w_nx_r0 = r_sh_r0;
    w_nx_g0 = r_sh_g0;
    w_nx_b0 = r_sh_b0;
    w_nx_r1 = r_sh_r1;
    w_nx_g1 = r_sh_g1;
    w_nx_b1 = r_sh_b1;
    w_nx_r0[r_cap_col] = w_top.r;
    w_nx_g0[r_cap_col] = w_top.g;
    w_nx_b0[r_cap_col] = w_top.b;
    w_nx_r1[r_cap_col] = w_bot.r;
    w_nx_g1[r_cap_col] = w_bot.g;
    w_nx_b1[r_cap_col] = w_bot.b;
  end

  always_ff @(posedge CLK_I) begin
    if (RST_I) begin
      r_state     <= IDLE;
      r_busy      <= 1'b0;
      r_front     <= 1'b0;
      r_pend      <= 1'b0;
      r_row_done  <= 1'b0;
      r_req_drop  <= 1'b0;
      r_swap_done <= 1'b0;
      r_row       <= '0;
      r_col       <= '0;
      r_cap_col   <= '0;
      r_cap_vld   <= 1'b0;
      {r_sh_r0, r_sh_g0, r_sh_b0, r_sh_r1, r_sh_g1, r_sh_b1} <= '0;
      {r_o_r0, r_o_g0, r_o_b0, r_o_r1, r_o_g1, r_o_b1}       <= '0;
    end else begin
      r_row_done  <= 1'b0;
      r_req_drop  <= 1'b0;
      r_swap_done <= 1'b0;
      r_cap_vld   <= (r_state == FETCH);
      r_cap_col   <= r_col;
      if (SWAP_REQ) r_pend <= 1'b1;
      if (ROW_REQ && r_state != IDLE) r_req_drop <= 1'b1;
      if (r_cap_vld) begin
        {r_sh_r0, r_sh_g0, r_sh_b0} <= {w_nx_r0, w_nx_g0, w_nx_b0};
        {r_sh_r1, r_sh_g1, r_sh_b1} <= {w_nx_r1, w_nx_g1, w_nx_b1};
      end
      case (r_state)
        IDLE: begin
          if (ROW_REQ) begin
            r_row   <= ROW_ADDR;
            r_col   <= '0;
            r_busy  <= 1'b1;
            r_state <= FETCH;
            // Swapping only at row 0 keeps every displayed frame whole.
            if (r_pend && ROW_ADDR == '0) begin
              r_front     <= ~r_front;
              r_swap_done <= 1'b1;
              if (!SWAP_REQ) r_pend <= 1'b0;
            end
          end
        end
        FETCH: begin
          if (r_col == COL_BITS'(COLS - 1)) begin
            r_col   <= '0;
            r_state <= LAST;
          end else begin
            r_col <= r_col + 1'b1;
          end
        end
        LAST: begin
          {r_o_r0, r_o_g0, r_o_b0} <= {w_nx_r0, w_nx_g0, w_nx_b0};
          {r_o_r1, r_o_g1, r_o_b1} <= {w_nx_r1, w_nx_g1, w_nx_b1};
          r_row_done <= 1'b1;
          r_state    <= DONE;
        end
        DONE: begin
          r_busy  <= 1'b0;
          r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign BUSY      = r_busy;
  assign ROW_DONE  = r_row_done;
  assign REQ_DROP  = r_req_drop;
  assign SWAP_DONE = r_swap_done;
  assign FRONT     = r_front;
  assign RED0      = r_o_r0;
  assign GREEN0    = r_o_g0;
  assign BLUE0     = r_o_b0;
  assign RED1      = r_o_r1;
  assign GREEN1    = r_o_g1;
  assign BLUE1     = r_o_b1;
  assign DBG_STATE = r_state;
endmodule

// File: tb/tb_matrix_row_loader.sv
// Directed bench for matrix_row_loader: fetch timing, bank split, buffering, swap deferral, drops, reset.
module tb_matrix_row_loader;
  import matrix_pkg::*;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          wr_en = 1'b0;
  logic [4:0]    wr_x = '0;
  logic [4:0]    wr_y = '0;
  logic [2:0]    wr_rgb = '0;
  logic          swap_req = 1'b0;
  logic          row_req = 1'b0;
  logic [3:0]    row_addr = '0;
  logic          busy, row_done, req_drop, swap_done, front;
  logic [31:0]   red0, green0, blue0, red1, green1, blue1;
  state_t        dbg_state;

  int n_total = 0;
  int n_bad   = 0;
  logic [31:0] exp_q[$];

  matrix_row_loader dut (
    .CLK_I(clk), .RST_I(rst), .WR_EN(wr_en), .WR_X(wr_x), .WR_Y(wr_y),
    .WR_RGB(wr_rgb), .SWAP_REQ(swap_req), .ROW_REQ(row_req), .ROW_ADDR(row_addr),
    .BUSY(busy), .ROW_DONE(row_done), .REQ_DROP(req_drop), .SWAP_DONE(swap_done),
    .FRONT(front), .RED0(red0), .GREEN0(green0), .BLUE0(blue0),
    .RED1(red1), .GREEN1(green1), .BLUE1(blue1), .DBG_STATE(dbg_state)
  );

  // Clock and watchdog
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog act=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s act=%h exp=%h", tag, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wr_px(input int x, input int y, input logic [2:0] rgb);
    wr_en = 1'b1; wr_x = 5'(x); wr_y = 5'(y); wr_rgb = rgb;
    step();
    wr_en = 1'b0;
  endtask

  task automatic wr_row(input int y, input logic [2:0] rgb);
    for (int x = 0; x < 32; x++) wr_px(x, y, rgb);
  endtask

  task automatic pulse_swap();
    swap_req = 1'b1;
    step();
    swap_req = 1'b0;
  endtask

  task automatic push6(input logic [31:0] r0, input logic [31:0] g0, input logic [31:0] b0,
                       input logic [31:0] r1, input logic [31:0] g1, input logic [31:0] b1);
    exp_q.push_back(r0); exp_q.push_back(g0); exp_q.push_back(b0);
    exp_q.push_back(r1); exp_q.push_back(g1); exp_q.push_back(b1);
  endtask

  task automatic chk_words(input string tag);
    if (exp_q.size() < 6) begin
      chk({tag, "_queue"}, 32'(exp_q.size()), 32'd6);
    end else begin
      chk({tag, "_red0"},   red0,   exp_q.pop_front());
      chk({tag, "_green0"}, green0, exp_q.pop_front());
      chk({tag, "_blue0"},  blue0,  exp_q.pop_front());
      chk({tag, "_red1"},   red1,   exp_q.pop_front());
      chk({tag, "_green1"}, green1, exp_q.pop_front());
      chk({tag, "_blue1"},  blue1,  exp_q.pop_front());
    end
  endtask

  // Request at edge 0, then watch cycles 1..36; drop_at>0 fires a second request at that edge.
  task automatic do_fetch(input string tag, input logic [3:0] addr, input logic exp_swap,
                          input logic exp_front, input int drop_at, input logic chk_data);
    int done_cyc = -1;
    int n_done = 0;
    row_addr = addr;
    row_req = 1'b1;
    step();
    row_req = 1'b0;
    chk({tag, "_busy_c1"}, 32'(busy), 32'd1);
    chk({tag, "_swap_done"}, 32'(swap_done), 32'(exp_swap));
    chk({tag, "_front"}, 32'(front), 32'(exp_front));
    for (int c = 1; c <= 36; c++) begin
      if (row_done) begin
        n_done++;
        if (n_done == 1) begin
          done_cyc = c;
          if (chk_data) chk_words(tag);
        end
      end
      if (drop_at > 0 && c == drop_at + 1) chk({tag, "_req_drop"}, 32'(req_drop), 32'd1);
      if (c == 34) chk({tag, "_busy_c34"}, 32'(busy), 32'd1);
      if (c == 35) chk({tag, "_busy_c35"}, 32'(busy), 32'd0);
      row_req = (drop_at > 0 && c == drop_at);
      step();
      row_req = 1'b0;
    end
    chk({tag, "_done_cnt"}, 32'(n_done), 32'd1);
    chk({tag, "_latency"}, 32'(done_cyc), 32'd34);
  endtask

  initial begin
    int n_done;
    repeat (3) step();
    rst = 1'b0;
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_front", 32'(front), 32'd0);
    chk("rst_pulses", {29'd0, row_done, req_drop, swap_done}, 32'd0);
    chk("rst_words", red0 | green0 | blue0 | red1 | green1 | blue1, 32'd0);

    // Basic fetch: frame 1 gets alternating red / cyan-ish columns
    for (int y = 0; y < 32; y++)
      for (int x = 0; x < 32; x++)
        wr_px(x, y, (x % 2 == 0) ? 3'b001 : 3'b110);
    pulse_swap();
    push6(32'h55555555, 32'hAAAAAAAA, 32'hAAAAAAAA, 32'h55555555, 32'hAAAAAAAA, 32'hAAAAAAAA);
    do_fetch("basic", 4'd0, 1'b1, 1'b1, 0, 1'b1);

    // Bank split: frame 0 gets rows 15/31 plus rows 3/19 for the isolation check
    wr_row(15, 3'b001);
    wr_row(31, 3'b100);
    wr_row(3, 3'b111);
    for (int x = 0; x < 32; x++) wr_px(x, 19, (x < 16) ? 3'b001 : 3'b010);
    pulse_swap();
    do_fetch("swap0", 4'd0, 1'b1, 1'b0, 0, 1'b0);
    push6(32'hFFFFFFFF, 32'h0, 32'h0, 32'h0, 32'h0, 32'hFFFFFFFF);
    do_fetch("split", 4'd15, 1'b0, 1'b0, 0, 1'b1);

    // Back-buffer isolation: rewrite rows 3/19 of frame 1, front stays frame 0
    wr_row(3, 3'b100);
    wr_row(19, 3'b010);
    push6(32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h0000FFFF, 32'hFFFF0000, 32'h0);
    do_fetch("iso", 4'd3, 1'b0, 1'b0, 0, 1'b1);

    // Swap deferral, with a doubled request that must not stack
    pulse_swap();
    pulse_swap();
    do_fetch("defer5", 4'd5, 1'b0, 1'b0, 0, 1'b0);
    push6(32'h55555555, 32'hAAAAAAAA, 32'hAAAAAAAA, 32'h55555555, 32'hAAAAAAAA, 32'hAAAAAAAA);
    do_fetch("defer0", 4'd0, 1'b1, 1'b1, 0, 1'b1);
    push6(32'h55555555, 32'hAAAAAAAA, 32'hAAAAAAAA, 32'h55555555, 32'hAAAAAAAA, 32'hAAAAAAAA);
    do_fetch("nostack", 4'd0, 1'b0, 1'b1, 0, 1'b1);

    // Busy drop: second request at edge 10 is ignored
    push6(32'h0, 32'h0, 32'hFFFFFFFF, 32'h0, 32'hFFFFFFFF, 32'h0);
    do_fetch("drop", 4'd3, 1'b0, 1'b1, 10, 1'b1);

    // Reset mid-fetch
    row_addr = 4'd0;
    row_req = 1'b1;
    step();
    row_req = 1'b0;
    n_done = 0;
    for (int c = 1; c < 20; c++) begin
      if (row_done) n_done++;
      step();
    end
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("mid_rst_busy", 32'(busy), 32'd0);
    chk("mid_rst_front", 32'(front), 32'd0);
    chk("mid_rst_words", red0 | green0 | blue0 | red1 | green1 | blue1, 32'd0);
    for (int c = 0; c < 20; c++) begin
      if (row_done) n_done++;
      step();
    end
    chk("mid_rst_no_done", 32'(n_done), 32'd0);
    push6(32'hFFFFFFFF, 32'h0, 32'h0, 32'h0, 32'h0, 32'hFFFFFFFF);
    do_fetch("after_rst", 4'd15, 1'b0, 1'b0, 0, 1'b1);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end
endmodule
